sync_fifo_reader: RTL and testbench

SYNC_FIFO_READER -- requirements
Module: sync_fifo_reader

---
 rtl/sync_fifo_reader.sv | 118 +++++++++++
 tb/tb_sync_fifo_reader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_reader.sv
// Drains a synchronous FIFO into a 3-entry output buffer and presents it as a valid/ready stream.
// Optional word counter output is built only when SYNC_FIFO_READER_WORD_COUNT_EN is defined.
module sync_fifo_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int FWFT       = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    output logic                  fifo_read_o,
    input  logic                  flush_i,
    input  logic                  m_ready_i,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o
`ifdef SYNC_FIFO_READER_WORD_COUNT_EN
    ,
    output logic [31:0]           word_count_o
`endif
);

    // Downstream handshake: a word transfers at a rising edge where m_valid_o && m_ready_i;
    // m_valid_o never waits on m_ready_i and m_data_o holds while m_valid_o && !m_ready_i.

    logic [DATA_WIDTH-1:0] mem_q [3];
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] head_d;
    logic [1:0]            wr_idx_q;
    logic [1:0]            wr_idx_d;
    logic [1:0]            rd_idx_q;
    logic [1:0]            rd_idx_d;
    logic [1:0]            occ_q;
    logic [1:0]            occ_d;
    logic [1:0]            occ_after_pop;
    logic                  pending_q;
    logic                  pending_d;
    logic                  valid_q;
    logic [2:0]            in_flight;
    logic                  read;
    logic                  push;
    logic                  pop;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // A read reserves a slot, so words still on the bus (pending) count against capacity.
    assign in_flight = {1'b0, occ_q} + {2'b00, pending_q};
    assign read      = !rst_i && !fifo_empty_i && !flush_i && (in_flight < 3'd3);
    assign push      = !flush_i && ((FWFT != 0) ? read : pending_q);
    assign pop       = valid_q && m_ready_i;

    assign fifo_read_o = read;
    assign m_valid_o   = valid_q;
    assign m_data_o    = head_q;

    always_comb begin
        occ_after_pop = pop ? occ_q - 2'd1 : occ_q;
        pending_d     = (FWFT != 0) ? 1'b0 : read;
        occ_d         = occ_q;
        rd_idx_d      = rd_idx_q;
        wr_idx_d      = wr_idx_q;
        head_d        = head_q;
        if (flush_i) begin
            occ_d    = 2'd0;
            rd_idx_d = 2'd0;
            wr_idx_d = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
            if (pop) rd_idx_d = next_idx(rd_idx_q);
            if (push) wr_idx_d = next_idx(wr_idx_q);
            // The new head either sits in the array already or is the word landing this edge.
            if (occ_d != 2'd0) begin
                if (push && occ_after_pop == 2'd0) head_d = fifo_rd_data_i;
                else                               head_d = mem_q[rd_idx_d];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_q     <= 2'd0;
            pending_q <= 1'b0;
            rd_idx_q  <= 2'd0;
            wr_idx_q  <= 2'd0;
            valid_q   <= 1'b0;
            head_q    <= '0;
        end else begin
            occ_q     <= occ_d;
            pending_q <= pending_d;
            rd_idx_q  <= rd_idx_d;
            wr_idx_q  <= wr_idx_d;
            valid_q   <= (occ_d != 2'd0);
            head_q    <= head_d;
        end
    end

    // Storage needs no reset: occupancy and indices decide what is meaningful.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_idx_q] <= fifo_rd_data_i;
    end

`ifdef SYNC_FIFO_READER_WORD_COUNT_EN
    logic [31:0] word_count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)    word_count_q <= 32'd0;
        else if (pop) word_count_q <= word_count_q + 32'd1;
    end

    assign word_count_o = word_count_q;
`endif

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Bench for sync_fifo_reader: one FWFT=1 and one FWFT=0 instance share stimulus, each fed by
// its own source-FIFO model, with a scoreboard queue and negedge monitor per instance.
module tb_sync_fifo_reader;
    localparam int W      = 32;
    localparam int N_RAND = 10000;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic ready;
    always #5 clk = ~clk;

    logic         empty1, empty0, stall1, stall0;
    logic [W-1:0] rd_data1, rd_data0;
    logic         read1, read0;
    logic         valid1, valid0;
    logic [W-1:0] data1, data0;
`ifdef SYNC_FIFO_READER_WORD_COUNT_EN
    logic [31:0]  wc1, wc0;
`endif

    logic [W-1:0] src_q1[$];
    logic [W-1:0] src_q0[$];
    logic [W-1:0] exp_q1[$];
    logic [W-1:0] exp_q0[$];

    int n_vec = 0;
    int n_err = 0;
    int hs1 = 0, hs0 = 0;
    int rd_cnt1 = 0, rd_cnt0 = 0;

    sync_fifo_reader #(.DATA_WIDTH(W), .FWFT(1)) dut_fwft (
        .clk_i(clk), .rst_i(rst), .fifo_empty_i(empty1), .fifo_rd_data_i(rd_data1),
        .fifo_read_o(read1), .flush_i(flush), .m_ready_i(ready), .m_valid_o(valid1),
        .m_data_o(data1)
`ifdef SYNC_FIFO_READER_WORD_COUNT_EN
        , .word_count_o(wc1)
`endif
    );

    sync_fifo_reader #(.DATA_WIDTH(W), .FWFT(0)) dut_std (
        .clk_i(clk), .rst_i(rst), .fifo_empty_i(empty0), .fifo_rd_data_i(rd_data0),
        .fifo_read_o(read0), .flush_i(flush), .m_ready_i(ready), .m_valid_o(valid0),
        .m_data_o(data0)
`ifdef SYNC_FIFO_READER_WORD_COUNT_EN
        , .word_count_o(wc0)
`endif
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic refresh();
        empty1   = stall1 || (src_q1.size() == 0);
        empty0   = stall0 || (src_q0.size() == 0);
        rd_data1 = (src_q1.size() != 0) ? src_q1[0] : '0;
    endtask

    task automatic load(input logic [W-1:0] w);
        src_q1.push_back(w);
        src_q0.push_back(w);
        exp_q1.push_back(w);
        exp_q0.push_back(w);
        refresh();
    endtask

    // One clock: sample the read strobes before the edge, update the source models 1ns after it.
    task automatic tick();
        logic         r1, r0;
        logic [W-1:0] tmp;
        @(negedge clk);
        r1 = read1;
        r0 = read0;
        @(posedge clk);
        #1;
        if (r1) begin
            rd_cnt1++;
            if (src_q1.size() != 0) tmp = src_q1.pop_front();
        end
        if (r0) begin
            rd_cnt0++;
            if (src_q0.size() != 0) rd_data0 = src_q0.pop_front();
        end
        refresh();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q1.size() != 0 || exp_q0.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        chk(name, W'(n < 200), 1);
    endtask

    // Monitor: checks every handshake against the scoreboard, hold stability and read legality.
    logic         p_valid1 = 1'b0, p_valid0 = 1'b0, p_ready = 1'b0;
    logic [W-1:0] p_data1 = '0, p_data0 = '0;
    initial forever begin
        @(negedge clk);
        chk("read_while_empty1", W'(read1 & empty1), 0);
        chk("read_while_empty0", W'(read0 & empty0), 0);
        if (valid1 && p_valid1 && !p_ready) chk("hold1", data1, p_data1);
        if (valid0 && p_valid0 && !p_ready) chk("hold0", data0, p_data0);
        if (valid1 && ready) begin
            if (exp_q1.size() == 0) chk("extra_word1", W'(exp_q1.size()), 1);
            else                    chk("order1", data1, exp_q1.pop_front());
            hs1++;
        end
        if (valid0 && ready) begin
            if (exp_q0.size() == 0) chk("extra_word0", W'(exp_q0.size()), 1);
            else                    chk("order0", data0, exp_q0.pop_front());
            hs0++;
        end
        p_valid1 = valid1;
        p_valid0 = valid0;
        p_data1  = data1;
        p_data0  = data0;
        p_ready  = ready;
    end

    initial begin
        int  cycles;
        int  loaded;
        bit  rst_done;
        rst      = 1'b1;
        flush    = 1'b0;
        ready    = 1'b1;
        stall1   = 1'b0;
        stall0   = 1'b0;
        rd_data0 = '0;
        refresh();

        // Reset state with words already waiting in the FIFO: no reads may issue.
        load(32'hA1); load(32'hA2); load(32'hA3);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_read1", W'(read1), 0);
        chk("rst_read0", W'(read0), 0);
        chk("rst_valid1", W'(valid1), 0);
        chk("rst_valid0", W'(valid0), 0);
        chk("rst_data1", data1, 0);
        chk("rst_data0", data0, 0);
`ifdef SYNC_FIFO_READER_WORD_COUNT_EN
        chk("rst_wcount1", wc1, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        refresh();

        // Streaming latency: FWFT=1 valid one edge after the first read, FWFT=0 two edges.
        tick(); chk("lat_valid1_e1", W'(valid1), 1); chk("lat_data1_e1", data1, 32'hA1);
                chk("lat_valid0_e1", W'(valid0), 0);
        tick(); chk("lat_data1_e2", data1, 32'hA2); chk("lat_data0_e2", data0, 32'hA1);
                chk("lat_valid0_e2", W'(valid0), 1);
        tick(); chk("lat_data1_e3", data1, 32'hA3); chk("lat_data0_e3", data0, 32'hA2);
        tick(); chk("lat_valid1_e4", W'(valid1), 0); chk("lat_data0_e4", data0, 32'hA3);
        tick(); chk("lat_valid0_e5", W'(valid0), 0);
        drain("drain_stream");

        // Back-pressure: five words queued, only three slots, so exactly three reads.
        ready   = 1'b0;
        rd_cnt1 = 0;
        rd_cnt0 = 0;
        load(32'hC1); load(32'hC2); load(32'hC3); load(32'hC4); load(32'hC5);
        repeat (8) tick();
        #1;
        chk("bp_reads1", rd_cnt1, 3);
        chk("bp_reads0", rd_cnt0, 3);
        chk("bp_read_now1", W'(read1), 0);
        chk("bp_read_now0", W'(read0), 0);
        chk("bp_head1", data1, 32'hC1);
        chk("bp_head0", data0, 32'hC1);
        ready = 1'b1;
        drain("drain_bp");

        // Flush the edge after a read while the FWFT=0 buffer holds two words.
        ready = 1'b0;
        load(32'hB1); load(32'hB2); load(32'hB3); load(32'hB4); load(32'hB5);
        repeat (3) tick();
        flush = 1'b1;
        #1;
        chk("flush_read1", W'(read1), 0);
        chk("flush_read0", W'(read0), 0);
        tick();
        flush = 1'b0;
        chk("flush_valid1", W'(valid1), 0);
        chk("flush_valid0", W'(valid0), 0);
        exp_q1.delete(); exp_q1.push_back(32'hB4); exp_q1.push_back(32'hB5);
        exp_q0.delete(); exp_q0.push_back(32'hB4); exp_q0.push_back(32'hB5);
        ready = 1'b1;
        refresh();
        tick(); chk("post_flush_data1", data1, 32'hB4); chk("post_flush_valid1", W'(valid1), 1);
        tick(); chk("post_flush_data0", data0, 32'hB4); chk("post_flush_valid0", W'(valid0), 1);
        drain("drain_flush");

        // Random ready/empty traffic, with one asynchronous reset part way through.
        cycles   = 0;
        loaded   = 0;
        rst_done = 1'b0;
        while (cycles < 60000 &&
               !(loaded == N_RAND && exp_q1.size() == 0 && exp_q0.size() == 0)) begin
            tick();
            cycles++;
            if (loaded >= N_RAND / 2 && !rst_done) begin
                rst_done = 1'b1;
                #1;
                rst = 1'b1;
                #1;
                chk("async_rst_valid1", W'(valid1), 0);
                chk("async_rst_valid0", W'(valid0), 0);
                chk("async_rst_read1", W'(read1), 0);
                chk("async_rst_read0", W'(read0), 0);
`ifdef SYNC_FIFO_READER_WORD_COUNT_EN
                chk("async_rst_wcount1", wc1, 0);
                chk("async_rst_wcount0", wc0, 0);
`endif
                src_q1.delete(); src_q0.delete();
                exp_q1.delete(); exp_q0.delete();
                hs1 = 0;
                hs0 = 0;
                refresh();
                tick();
                tick();
                rst = 1'b0;
            end
            ready  = ($urandom_range(0, 3) != 0);
            stall1 = ($urandom_range(0, 3) == 0);
            stall0 = ($urandom_range(0, 3) == 0);
            while (loaded < N_RAND && (src_q1.size() < 4 || src_q0.size() < 4)) begin
                load($urandom);
                loaded++;
            end
            refresh();
        end
        chk("random_complete", W'(exp_q1.size() + exp_q0.size()), 0);
        tick();
`ifdef SYNC_FIFO_READER_WORD_COUNT_EN
        chk("wcount1", wc1, W'(hs1));
        chk("wcount0", wc0, W'(hs0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
